// File: rtl/transmissor_arduino_pkg.sv
// Shared constants and types for the FPGA-to-Arduino sound command link.
// The Arduino firmware decodes commands using these same field positions.
package transmissor_arduino_pkg;

    typedef enum logic [2:0] {
        OCIOSO = 3'd0,
        START  = 3'd1,
        DADOS  = 3'd2,
        STOP   = 3'd3
    } estado_t;

    localparam int POS_ATIVO           = 7;
    localparam int POS_SEL             = 6;
    localparam int NOTA_MSB            = 3;
    localparam int NOTA_LSB            = 0;
    localparam int CLKS_PER_BIT_PADRAO = 434;

    // Bits 5:4 are reserved and always sent as zero.
    function automatic logic [7:0] monta_byte(input logic ativo, input logic sel,
                                              input logic [3:0] nota);
        logic [7:0] b;
        b                    = '0;
        b[POS_ATIVO]         = ativo;
        b[POS_SEL]           = sel;
        b[NOTA_MSB:NOTA_LSB] = nota;
        return b;
    endfunction

endpackage

// File: rtl/transmissor_arduino_if.sv
// Command inputs from the game datapath and serial/status outputs of the transmitter.
interface transmissor_arduino_if;
    logic       ativo;
    logic       sel_memoria;
    logic [3:0] nota;
    logic       tx;
    logic       ocupado;
    logic       enviado;
    logic [2:0] db_estado;

    modport master (output ativo, sel_memoria, nota,
                    input  tx, ocupado, enviado, db_estado);
    modport slave  (input  ativo, sel_memoria, nota,
                    output tx, ocupado, enviado, db_estado);
endinterface

// File: rtl/transmissor_arduino_gerador_baud.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and ticks fim_bit on the last cycle of each bit.
module gerador_baud
    import transmissor_arduino_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_PADRAO
) (
    input  logic clock,
    input  logic reset,
    input  logic limpa,
    output logic fim_bit,
    output logic quase_fim
);
    localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [W-1:0] CNT_MAX = W'(CLKS_PER_BIT - 1);
    localparam logic [W-1:0] CNT_PEN = W'(CLKS_PER_BIT - 2);

    logic [W-1:0] cnt_q, cnt_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (limpa || cnt_q == CNT_MAX) cnt_d = '0;
        else                           cnt_d = cnt_q + W'(1);
    end

    // NOTE: reset is synchronous and active-high; state uses non-blocking assignments only.
    always_ff @(posedge clock) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign fim_bit   = !limpa && (cnt_q == CNT_MAX);
    // One cycle early, so the owner can register a pulse aligned with fim_bit.
    assign quase_fim = !limpa && (cnt_q == CNT_PEN);

endmodule

// File: rtl/transmissor_arduino.sv
// 8N1 UART transmitter that sends the sound command byte whenever it differs from the last one sent.
module transmissor_arduino
    import transmissor_arduino_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_PADRAO
) (
    input  logic                  clock,
    input  logic                  reset,
    transmissor_arduino_if.slave  bus
);
    estado_t    estado_q, estado_d;
    logic [7:0] ultimo_q, ultimo_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_q, bit_d;
    logic       tx_q, tx_d;
    logic       ocupado_q, ocupado_d;
    logic       enviado_q, enviado_d;
    logic       limpa, fim_bit, quase_fim;
    logic [7:0] byte_cmd;

    gerador_baud #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clock     (clock),
        .reset     (reset),
        .limpa     (limpa),
        .fim_bit   (fim_bit),
        .quase_fim (quase_fim)
    );

    assign byte_cmd = monta_byte(bus.ativo, bus.sel_memoria, bus.nota);

    always_comb begin
        estado_d = estado_q;
        ultimo_d = ultimo_q;
        shift_d  = shift_q;
        bit_d    = bit_q;
        limpa    = 1'b0;
        unique case (estado_q)
            OCIOSO: begin
                limpa = 1'b1;
                // Inputs are only sampled here; whatever changed mid-frame, the latest value wins.
                if (byte_cmd != ultimo_q) begin
                    shift_d  = byte_cmd;
                    ultimo_d = byte_cmd;
                    bit_d    = '0;
                    estado_d = START;
                end
            end
            START: if (fim_bit) estado_d = DADOS;
            DADOS: begin
                if (fim_bit) begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) estado_d = STOP;
                end
            end
            STOP: if (fim_bit) estado_d = OCIOSO;
            default: begin
                limpa    = 1'b1;
                estado_d = OCIOSO;
            end
        endcase
    end

    // Outputs are decoded from the next state so they land in flops alongside it.
    always_comb begin
        tx_d = 1'b1;
        case (estado_d)
            START:   tx_d = 1'b0;
            DADOS:   tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
        ocupado_d = (estado_d != OCIOSO);
        enviado_d = (estado_q == STOP) && quase_fim;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q  <= OCIOSO;
            ultimo_q  <= '0;
            shift_q   <= '0;
            bit_q     <= '0;
            tx_q      <= 1'b1;
            ocupado_q <= 1'b0;
            enviado_q <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            ultimo_q  <= ultimo_d;
            shift_q   <= shift_d;
            bit_q     <= bit_d;
            tx_q      <= tx_d;
            ocupado_q <= ocupado_d;
            enviado_q <= enviado_d;
        end
    end

    assign bus.tx        = tx_q;
    assign bus.ocupado   = ocupado_q;
    assign bus.enviado   = enviado_q;
    assign bus.db_estado = estado_q;

endmodule

// File: doc/transmissor_arduino.md
# transmissor_arduino

Serial transmitter that carries the game's sound requests from the FPGA to the Arduino sound board. It sits in the datapath next to the game control unit and watches three signals: `activateArduino`, `sel_memoria_arduino`, and the 4-bit note code selected by the memory/button mux. Whenever the composed command byte differs from the last byte sent, it sends that byte as one 8N1 UART frame on a single line.

## Interface
- `CLKS_PER_BIT`, default 434 (50 MHz / 115200 baud): clock cycles per serial bit; legal minimum 2.
- `clock`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ativo`  in  1  connect to `activateArduino`; becomes byte bit 7.
- `sel_memoria`  in  1  connect to `sel_memoria_arduino` (1 = sequence playback, 0 = player buttons); becomes byte bit 6.
- `nota`  in  4  note code; becomes byte bits 3:0.
- `tx`  out  1  serial line to the Arduino; idle high.
- `ocupado`  out  1  high while a frame is in flight (any state other than OCIOSO).
- `enviado`  out  1  one-cycle pulse on the last cycle of the stop bit.
- `db_estado`  out  3  current state code, for debug.

## Operation
- Command byte, combinational: `{ativo, sel_memoria, 2'b00, nota}`.
- Register `ultimo` holds the last byte committed for sending.
- States and codes:
  - OCIOSO (0): `tx`=1. If the command byte ≠ `ultimo`, then on the next edge load the byte into the shift register and into `ultimo`, clear the bit counter, and go to START. Otherwise stay.
  - START (1): `tx`=0 for `CLKS_PER_BIT` cycles, then go to DADOS.
  - DADOS (2): `tx` = shift register bit 0, LSB first. Shift right every `CLKS_PER_BIT` cycles. After the 8th bit period, go to STOP.
  - STOP (3): `tx`=1 for `CLKS_PER_BIT` cycles. `enviado`=1 on the final cycle, then go to OCIOSO.
  - Unused codes 4–7 go to OCIOSO on the next edge, with `tx`=1.
- Inputs are sampled only in OCIOSO. Changes during a frame are not queued. After the frame, OCIOSO compares the current byte with `ultimo`: the newest value is sent, and a change that reverted to `ultimo` produces no frame (last value wins).
- When the byte equals `ultimo`, the block stays in OCIOSO indefinitely with no output activity.
- Reset values: state OCIOSO, `ultimo`=8'h00, shift register 0, counters 0, `tx`=1, `ocupado`=0, `enviado`=0, `db_estado`=0.
- Reset mid-frame aborts the frame: `tx`=1 from the next edge, and no `enviado` pulse is produced.
- Because `ultimo` resets to 8'h00, a control unit sitting in its initial state (`ativo`=0, `nota`=0) causes no transmission after reset.

## Timing
- All outputs are registered. `tx` changes only on clock edges.
- Latency: byte change visible at edge k in OCIOSO → `tx` falls after edge k+1.
- Frame length: exactly 10·`CLKS_PER_BIT` cycles from the `tx` falling edge to the end of the stop bit.
- Back-to-back frames: if the byte changed during a frame, the next start bit begins 1 cycle after the `enviado` cycle (one OCIOSO cycle in between).
- Baud counter width: `$clog2(CLKS_PER_BIT)`, counting 0..`CLKS_PER_BIT`-1 and wrapping. Bit counter: 3 bits, counting 0..7.

## Structure
- Shared package holds:
  - the state encoding (OCIOSO/START/DADOS/STOP as a 3-bit typedef),
  - the byte field positions (bit 7 ativo, bit 6 sel_memoria, bits 3:0 nota),
  - the default `CLKS_PER_BIT` constant. The Arduino firmware spec cites these same values.
- One natural sub-module: `gerador_baud`, the baud counter with clear and a one-cycle `fim_bit` tick. The FSM and shift register stay in the top module.

## Test plan
All scenarios use `CLKS_PER_BIT`=4.
- Reset with inputs all 0 → `tx`=1, `ocupado`=0 for 100 cycles, no `enviado` pulse.
- `ativo`=1, `sel_memoria`=1, `nota`=4'h5 (byte 8'hC5) → `tx` low at edge k+1, then data bits 1,0,1,0,0,0,1,1 at 4 cycles each, then stop; `enviado` on cycle 40 of the frame; `ocupado` low afterwards.
- During a frame, `nota` goes 5→7→5 (returns to the value being sent) → exactly one frame (8'hC5), no second frame.
- During a frame, `nota` changes 5→9 and holds → second frame 8'hC9 starts 1 cycle after `enviado`.
- Reset asserted during DADOS → `tx`=1 from the next edge, no `enviado` pulse. After reset release with byte 8'hC5 still applied, a fresh full frame of 8'hC5 is sent (because `ultimo` was cleared to 8'h00).
- Force state register to 3'b110 → returns to OCIOSO next edge with `tx`=1.
